// File: rtl/spi_pkg.sv
// ============================================================================
// Module      : spi_pkg
// Description : Shared SPI types and helpers (slave state encoding, length
//               decode and frame mask) used by spi_mst and spi_slv.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

   localparam int SPI_MAX_BITS = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } spi_slv_st_e;

   // Length field 0 encodes a full 32-bit frame.
   function automatic logic [5:0] spi_nbits(input logic [3:0] len);
      return (len == 4'd0) ? 6'd32 : ({2'b00, len} + 6'd1);
   endfunction

   function automatic logic [SPI_MAX_BITS-1:0] spi_mask(input logic [5:0] nbits);
      return (nbits >= 6'd32) ? {SPI_MAX_BITS{1'b1}}
                              : ((32'd1 << nbits) - 32'd1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_slv_sync.sv
// ============================================================================
// Module      : spi_slv_sync
// Description : Synchronises spi_clk / cs_n / mosi into clk and produces
//               leading/trailing edge strobes relative to the idle level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slv_sync #(
   parameter int SYNC_STG = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic spi_clk_i,
   input  logic cs_n_i,
   input  logic mosi_i,
   input  logic ci_i,
   output logic mosi_s_o,
   output logic cs_n_s_o,
   output logic lead_o,
   output logic trail_o
);

   logic [SYNC_STG-1:0] sclk_q;
   logic [SYNC_STG-1:0] cs_q;
   logic [SYNC_STG-1:0] mosi_q;
   logic                sclk_prev_q;
   logic                sclk_s;
   logic                sclk_chg;

   // Chip select resets high so no frame is seen while coming out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q      <= '0;
         cs_q        <= '1;
         mosi_q      <= '0;
         sclk_prev_q <= 1'b0;
      end else begin
         sclk_q      <= {sclk_q[SYNC_STG-2:0], spi_clk_i};
         cs_q        <= {cs_q[SYNC_STG-2:0], cs_n_i};
         mosi_q      <= {mosi_q[SYNC_STG-2:0], mosi_i};
         sclk_prev_q <= sclk_q[SYNC_STG-1];
      end
   end

   assign sclk_s   = sclk_q[SYNC_STG-1];
   assign sclk_chg = sclk_s ^ sclk_prev_q;
   assign lead_o   = sclk_chg & (sclk_s ^ ci_i);
   assign trail_o  = sclk_chg & ~(sclk_s ^ ci_i);
   assign mosi_s_o = mosi_q[SYNC_STG-1];
   assign cs_n_s_o = cs_q[SYNC_STG-1];

endmodule

`default_nettype wire

// File: rtl/spi_slv.sv
// ============================================================================
// Module      : spi_slv
// Description : SPI responder with register-style host interface.
//               Optional macro SPI_SLV_ECHO_EN: an underrun frame returns the
//               last received word instead of zeros.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slv
   import spi_pkg::*;
#(
   parameter int SYNC_STG = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        spi_clk,
   input  logic        spi_cs_n,
   input  logic        spi_mosi,
   output logic        spi_miso,
   input  logic        r_spi_ci,
   input  logic        r_spi_cp,
   input  logic [3:0]  r_spi_len,
   input  logic [31:0] r_spi_txd,
   input  logic        r_spi_txld,
   output logic        r_spi_txrdy,
   output logic [31:0] r_spi_rxd,
   output logic        r_spi_rxvld,
   output logic        r_spi_ovr,
   output logic        r_spi_udr,
   output logic        r_spi_abrt,
   input  logic        r_spi_clr
);

   spi_slv_st_e            state_q, state_d;
   logic                   abort_d;
   logic                   mosi_s, cs_n_s, lead, trail;
   logic                   sample, launch, last;
   logic                   ci_q, cp_q, armed_q;
   logic [5:0]             nbits_q, bit_cnt_q;
   logic [4:0]             miso_idx;
   logic [SPI_MAX_BITS-1:0] tx_sh_q, rx_sh_q, hold_q, rxd_q, fill;
   logic                   txrdy_q, rxvld_q, pend_q, ovr_q, udr_q, abrt_q;

   spi_slv_sync #(.SYNC_STG(SYNC_STG)) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi_clk_i (spi_clk),
      .cs_n_i    (spi_cs_n),
      .mosi_i    (spi_mosi),
      .ci_i      (ci_q),
      .mosi_s_o  (mosi_s),
      .cs_n_s_o  (cs_n_s),
      .lead_o    (lead),
      .trail_o   (trail)
   );

   // With cp=1 the first bit is already on MISO from LOAD, so the first lead
   // (bit_cnt still 0) must not shift it away.
   assign sample = cp_q ? trail : lead;
   assign launch = cp_q ? (lead && (bit_cnt_q != 6'd0)) : trail;
   assign last   = sample && ((bit_cnt_q + 6'd1) == nbits_q);

`ifdef SPI_SLV_ECHO_EN
   assign fill = rxd_q;
`else
   assign fill = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      abort_d = 1'b0;
      case (state_q)
         IDLE:  if (armed_q && !cs_n_s) state_d = LOAD;
         LOAD:  state_d = SHIFT;
         SHIFT: begin
            if (last) begin
               state_d = DONE;
            end else if (cs_n_s) begin
               state_d = IDLE;
               abort_d = 1'b1;
            end
         end
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ci_q      <= 1'b0;
         cp_q      <= 1'b0;
         armed_q   <= 1'b0;
         nbits_q   <= 6'd32;
         bit_cnt_q <= '0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         hold_q    <= '0;
         rxd_q     <= '0;
         txrdy_q   <= 1'b1;
         rxvld_q   <= 1'b0;
         pend_q    <= 1'b0;
         ovr_q     <= 1'b0;
         udr_q     <= 1'b0;
         abrt_q    <= 1'b0;
      end else begin
         rxvld_q <= (state_q == DONE);
         abrt_q  <= abort_d;

         if (cs_n_s)                armed_q <= 1'b1;
         else if (state_q == LOAD)  armed_q <= 1'b0;

         if (r_spi_clr) begin
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
            udr_q  <= 1'b0;
         end

         if (state_q == LOAD) begin
            ci_q      <= r_spi_ci;
            cp_q      <= r_spi_cp;
            nbits_q   <= spi_nbits(r_spi_len);
            bit_cnt_q <= '0;
            rx_sh_q   <= '0;
            tx_sh_q   <= txrdy_q ? fill : hold_q;
            txrdy_q   <= 1'b1;
            if (txrdy_q) udr_q <= 1'b1;
         end

         if (state_q == SHIFT) begin
            if (sample) begin
               rx_sh_q   <= {rx_sh_q[SPI_MAX_BITS-2:0], mosi_s};
               bit_cnt_q <= bit_cnt_q + 6'd1;
            end
            if (launch) tx_sh_q <= {tx_sh_q[SPI_MAX_BITS-2:0], 1'b0};
         end

         if (state_q == DONE) begin
            rxd_q  <= rx_sh_q & spi_mask(nbits_q);
            pend_q <= 1'b1;
            if (pend_q) ovr_q <= 1'b1;
         end

         // A host load always lands in the holding register, never the shifter.
         if (r_spi_txld) begin
            hold_q  <= r_spi_txd;
            txrdy_q <= 1'b0;
         end
      end
   end

   assign miso_idx    = nbits_q[4:0] - 5'd1;
   assign spi_miso    = ~spi_cs_n & tx_sh_q[miso_idx];
   assign r_spi_txrdy = txrdy_q;
   assign r_spi_rxd   = rxd_q;
   assign r_spi_rxvld = rxvld_q;
   assign r_spi_ovr   = ovr_q;
   assign r_spi_udr   = udr_q;
   assign r_spi_abrt  = abrt_q;

endmodule

`default_nettype wire

// File: doc/spi_slv.md
Name: spi_slv

Overview:
- SPI responder: the far end of spi_mst. Receives a frame on spi_mosi and returns a transmit word on spi_miso.
- spi_clk, spi_cs_n and spi_mosi are asynchronous. They are synchronised into clk and all edge handling is done in the clk domain.
- Host side is register-style, matching spi_mst: same CPOL/CPHA/length encoding, an rx word with a valid pulse, and a tx holding register with a load handshake.
- clk must run at least 8x spi_clk.

Parameters:
- SYNC_STG, 2, number of synchroniser flops on spi_clk, spi_cs_n and spi_mosi (legal range 2..3).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- spi_clk  in  1  serial clock from master
- spi_cs_n  in  1  chip select, active low
- spi_mosi  in  1  master-out data
- spi_miso  out  1  slave-out data
- r_spi_ci  in  1  clock idle level (CPOL)
- r_spi_cp  in  1  phase; 0 = sample on leading edge, 1 = sample on trailing edge
- r_spi_len  in  4  frame length; 0 = 32 bits, n = n+1 bits
- r_spi_txd  in  32  tx word, right-aligned
- r_spi_txld  in  1  load pulse for r_spi_txd
- r_spi_txrdy  out  1  tx holding register empty
- r_spi_rxd  out  32  last received word, right-aligned
- r_spi_rxvld  out  1  one-cycle pulse, frame complete
- r_spi_ovr  out  1  sticky: a frame completed while the previous rxvld was not cleared
- r_spi_udr  out  1  sticky: a frame started with no tx word loaded
- r_spi_abrt  out  1  one-cycle pulse, CS released mid-frame
- r_spi_clr  in  1  clears the ovr, udr and rxvld-pending flags

Behaviour:
Reset values:
- All outputs 0, except r_spi_txrdy = 1.
- State IDLE; shift registers 0.

Synchronisation and edge detect:
- SYNC_STG flops, then a registered edge detect.
- Edge-to-action latency is SYNC_STG+1 clk.
- lead = transition of the synced spi_clk away from r_spi_ci; trail = transition back to it.

State machine (IDLE, LOAD, SHIFT, DONE):
- IDLE -> LOAD when synced cs_n falls.
- LOAD, 1 clk:
  - tx_sh <= held tx word, left-justified to bit nbits-1; fill is 0 if the holding register is empty, and udr is set.
  - txrdy <= 1.
  - bit_cnt <= 0.
  - Go to SHIFT.
- SHIFT:
  - Sample event (lead if cp=0, else trail): rx_sh <= {rx_sh[30:0], mosi_s}; bit_cnt++.
  - Launch event (trail if cp=0, else lead, excluding the first lead when cp=1): tx_sh <<= 1.
  - When bit_cnt == nbits after a sample: go to DONE.
  - If cs_n rises first: pulse abrt, discard rx_sh, go to IDLE; rxd is not updated.
- DONE, 1 clk:
  - r_spi_rxd <= rx_sh masked to nbits.
  - Pulse rxvld; if the previous rxvld is still pending (not cleared), set ovr.
  - Return to IDLE. Further spi_clk edges before cs_n rises are ignored.
  - Re-arm requires cs_n high for at least 1 synced cycle.

Frame length and MISO:
- nbits = (r_spi_len == 0) ? 32 : r_spi_len + 1.
- r_spi_len, ci and cp are sampled in LOAD; changes mid-frame are ignored.
- spi_miso = tx_sh[nbits-1] combinationally while cs_n is low, else 0.
- In cp=0 the first bit is valid from LOAD; the master must allow SYNC_STG+2 clk from cs_n fall to the first edge.

TX handshake:
- r_spi_txld while txrdy = 1 captures r_spi_txd and drops txrdy.
- r_spi_txld while txrdy = 0 overwrites the held word; no flag.
- A load during SHIFT goes to the holding register and never alters the active frame.

Simultaneous events:
- clr and an ovr/udr set in the same cycle: set wins.
- cs_n rise in the same synced cycle as the final sample: frame completes (DONE), no abort.

Optional Feature:
- Macro: SPI_SLV_ECHO_EN.
- When defined: in LOAD with an empty holding register, tx_sh is loaded with the last r_spi_rxd instead of 0. udr is still set. Gives master-side loopback checking over the wire.
- When undefined: fill is 0.

Decomposition:
- Shared package spi_pkg:
  - state enum spi_slv_st_e {IDLE, LOAD, SHIFT, DONE};
  - function spi_nbits(len) returning 6 bits;
  - constant SPI_MAX_BITS = 32.
  - spi_mst's length decode moves to the same function.
- One sub-module spi_slv_sync: parameterised SYNC_STG synchroniser plus edge detect for spi_clk, producing mosi_s, cs_n_s, lead and trail, with async active-low reset.

Test Plan:
- Mode 0 (ci=0, cp=0), len=0, txd=0xA5A5_0F0F loaded, master sends 0x1234_5678 -> rxd=0x1234_5678, rxvld 1 pulse, master sees 0xA5A5_0F0F, txrdy=1 after LOAD.
- All four ci/cp modes, len=7, tx=0x3C, master sends 0xC3 -> rxd=0x0000_00C3, master sees 0x3C in each mode.
- No tx loaded, 16-bit frame (len=15) -> udr=1, miso all 0 (0x5A5A on the previous rxd with SPI_SLV_ECHO_EN); r_spi_clr clears udr.
- Two 8-bit frames without r_spi_clr -> ovr=1 after the second; rxd holds the second word.
- cs_n raised after 5 of 8 bits -> abrt 1 pulse, no rxvld, rxd unchanged; next full frame is received correctly.
- rst_n asserted mid-SHIFT -> outputs at reset values immediately; the following frame after release completes normally.
